// File: rtl/sc_spi_arb.sv
// Round-robin arbiter/sequencer sharing one SPI protocol controller among
// NUM_REQ requesters. It grants the engine, latches the winner's frame config,
// pulses SPISTART, and tracks SPIBUSY until the frame completes. It also
// supports locked multi-frame sequences (CS held) and a start-ack timeout.
//
// Handshake: a requester raises REQ[i] and holds it until its DONE[i] pulse.
// GNT is one-hot and stays stable for the whole frame, or for the whole
// locked sequence. SPISTART is a single-cycle request to the engine. The
// engine acknowledges by raising SPIBUSY and signals completion by dropping
// SPIBUSY. All outputs are registered.
module sc_spi_arb #(
  parameter int NUM_REQ = 4,
  parameter int ACK_TMO = 3
) (
  input  logic                 SPICLK,
  input  logic                 SYSRSTB,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [NUM_REQ-1:0]   LOCK,
  input  logic [5*NUM_REQ-1:0] REQ_CSSEL,
  input  logic [9*NUM_REQ-1:0] REQ_DWIDTH,
  input  logic [2*NUM_REQ-1:0] REQ_MODE,
  output logic [NUM_REQ-1:0]   GNT,
  output logic [NUM_REQ-1:0]   DONE,
  output logic                 ERR,
  output logic [2:0]           OWNER,
  output logic                 SPISTART,
  input  logic                 SPIBUSY,
  output logic [4:0]           CSSEL,
  output logic [8:0]           DWIDTH,
  output logic                 CPOL,
  output logic                 CPHA,
  output logic                 CSEXTEND,
  output logic [2:0]           DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ACK   = 3'd2,
    S_RUN   = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic [2:0]           owner_q, owner_d;
  logic                 spistart_q, spistart_d;
  logic [4:0]           cssel_q, cssel_d;
  logic [8:0]           dwidth_q, dwidth_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic                 csext_q, csext_d;
  logic [2:0]           rr_last_q, rr_last_d;
  logic [3:0]           ack_cnt_q, ack_cnt_d;

  logic                 win_found;
  logic [2:0]           win_idx;
  int                   cand;
  logic [2:0]           sel_idx;
  logic [4:0]           sel_cssel;
  logic [8:0]           sel_dwidth;
  logic [1:0]           sel_mode;
  logic                 sel_lock;
  logic                 own_lock;
  logic                 own_req;

  // Round-robin pick: first set REQ scanning upward from rr_last+1, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_last_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && cand == i && REQ[i]) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
        end
      end
    end
  end

  // Config source: the arbitration winner in IDLE, the current owner on a locked re-start
  assign sel_idx = (state_q == S_END) ? owner_q : win_idx;

  // Mux the selected requester's config and the owner's LOCK/REQ levels
  always_comb begin
    sel_cssel  = '0;
    sel_dwidth = '0;
    sel_mode   = '0;
    sel_lock   = 1'b0;
    own_lock   = 1'b0;
    own_req    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == 3'(i)) begin
        sel_cssel  = REQ_CSSEL[5*i +: 5];
        sel_dwidth = REQ_DWIDTH[9*i +: 9];
        sel_mode   = REQ_MODE[2*i +: 2];
        sel_lock   = LOCK[i];
      end
      if (owner_q == 3'(i)) begin
        own_lock = LOCK[i];
        own_req  = REQ[i];
      end
    end
  end

  // Next-state and next-output logic of the grant/start/track sequencer
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    cssel_d    = cssel_q;
    dwidth_d   = dwidth_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    csext_d    = csext_q;
    rr_last_d  = rr_last_q;
    ack_cnt_d  = ack_cnt_q;
    spistart_d = 1'b0;
    done_d     = '0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found && !SPIBUSY) begin
          gnt_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d   = win_idx;
          cssel_d   = sel_cssel;
          dwidth_d  = sel_dwidth;
          cpol_d    = sel_mode[1];
          cpha_d    = sel_mode[0];
          csext_d   = sel_lock;
          rr_last_d = win_idx;
          state_d   = S_START;
        end
      end
      S_START: begin
        spistart_d = 1'b1;
        ack_cnt_d  = '0;
        state_d    = S_ACK;
      end
      S_ACK: begin
        if (SPIBUSY) begin
          state_d = S_RUN;
        end else if (ack_cnt_q == 4'(ACK_TMO - 1)) begin
          // Engine never acknowledged: release the owner and flag the error
          err_d   = 1'b1;
          done_d  = gnt_q;
          gnt_d   = '0;
          csext_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
        end
      end
      S_RUN: begin
        csext_d = own_lock;
        if (!SPIBUSY) begin
          done_d  = gnt_q;
          state_d = S_END;
        end
      end
      S_END: begin
        if (own_lock && own_req) begin
          // Locked sequence: same owner, no arbitration, config re-latched
          cssel_d  = sel_cssel;
          dwidth_d = sel_dwidth;
          cpol_d   = sel_mode[1];
          cpha_d   = sel_mode[0];
          csext_d  = 1'b1;
          state_d  = S_START;
        end else begin
          gnt_d   = '0;
          csext_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        csext_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge SPICLK) begin
    if (!SYSRSTB) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      owner_q    <= '0;
      spistart_q <= 1'b0;
      cssel_q    <= '0;
      dwidth_q   <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      csext_q    <= 1'b0;
      rr_last_q  <= 3'(NUM_REQ - 1);
      ack_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      owner_q    <= owner_d;
      spistart_q <= spistart_d;
      cssel_q    <= cssel_d;
      dwidth_q   <= dwidth_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      csext_q    <= csext_d;
      rr_last_q  <= rr_last_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  assign GNT       = gnt_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign OWNER     = owner_q;
  assign SPISTART  = spistart_q;
  assign CSSEL     = cssel_q;
  assign DWIDTH    = dwidth_q;
  assign CPOL      = cpol_q;
  assign CPHA      = cpha_q;
  assign CSEXTEND  = csext_q;
  assign DBG_STATE = state_q;

endmodule
